req_arbiter8: RTL and testbench
===============================

# req_arbiter8

Eight-way request arbiter that shares one downstream resource, such as an encoder or a shared bus port, among eight requesters. It picks a winner with a highest-index-first priority search and issues a registered one-hot grant plus its 3-bit index. It holds the grant until the owner signals completion, drops its request, or exceeds a hold limit. It sits between the requester bank and the shared datapath and is the only block that drives that datapath's select.

## Interface
- MAX_HOLD, 16, maximum number of cycles one owner may keep the grant; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  arbitration enable; low blocks new grants and revokes any current grant.
- req  input  8  request lines; bit i belongs to requester i; level-sensitive.
- done  input  1  one-cycle pulse from the current owner marking end of use.
- gnt  output  8  one-hot grant; all zero when there is no owner.
- gnt_idx  output  3  binary index of the owner; 3'd0 when gnt_valid is low.
- gnt_valid  output  1  high while gnt is non-zero.
- timeout  output  1  one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

## Operation
- Reset values: gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0, state=IDLE, hold counter=0, priority pointer ptr=3'd7.
- States: IDLE, BUSY, RELEASE.
- IDLE: if en=1 and req≠0, the search starts at index ptr and moves downward with wrap (ptr, ptr-1, ..., 0, 7, ...). The first set bit wins. The block registers gnt, gnt_idx, gnt_valid=1, clears the hold counter and moves to BUSY. Otherwise it stays in IDLE.
- BUSY: the hold counter increments every cycle. The grant ends at the first clock edge where any of these holds:
  - (a) done=1;
  - (b) req[gnt_idx]=0;
  - (c) the counter equals MAX_HOLD-1, which also pulses timeout;
  - (d) en=0.
- Release priority when several conditions hold in the same cycle: (d), then (a), then (b), then (c). timeout pulses only when (c) alone causes the release.
- On release: gnt, gnt_idx and gnt_valid clear on the same edge, and the state moves to RELEASE.
- RELEASE: a one-cycle dead cycle with no grant, which guarantees break-before-make on the shared resource. Next state is IDLE unconditionally.
- ptr updates on each grant to winner i; the update rule is set under Configuration.
- done while in IDLE or RELEASE is ignored.
- req changes on non-owner bits during BUSY are ignored until the next IDLE.
- Reset asserted mid-grant drops all outputs immediately (asynchronously) to their reset values.

## Timing
- Grant latency: req sampled high at edge k in IDLE gives gnt valid after edge k. Minimum of 1 cycle from request to grant.
- Release latency: done high at edge k gives gnt low after edge k. The earliest new grant appears after edge k+2 (RELEASE at k+1, then arbitration in IDLE).
- Hold limit: the grant is visible for exactly MAX_HOLD cycles when never released early. timeout is high for the single cycle following the revoking edge, aligned with gnt going low.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Back-to-back service cadence: one grant per MAX_HOLD+2 cycles at worst, and one grant per 3 cycles when every owner pulses done on its first granted cycle.

## Configuration
- ROUND_ROBIN_EN defined: after a grant to index i, ptr becomes (i-1) mod 8. The last winner becomes lowest priority. Any continuously asserted request is granted within 8 arbitration rounds.
- ROUND_ROBIN_EN undefined: ptr stays at 3'd7 permanently. This is a fixed high-priority encoder order: 7 always beats 6, and so on down to 0. Starvation of low indices is allowed.

## Test plan
- Reset mid-grant: owner 5 holds the grant, rst_n is pulled low between edges -> gnt=0, gnt_valid=0 and gnt_idx=0 immediately. After release of reset, ptr=7.
- Single request: req=8'h04 with en=1 -> gnt=8'h04, gnt_idx=2 one cycle later. Pulse done -> gnt=0 next cycle, then RELEASE, then IDLE.
- Priority order with ROUND_ROBIN_EN undefined: req=8'h81 held high and done pulsed on each grant -> gnt_idx is 7 every time; index 0 is never granted.
- Rotation with ROUND_ROBIN_EN defined: req=8'h81 held high and done pulsed on each grant -> gnt_idx alternates 7, 0, 7, 0.
- Timeout: MAX_HOLD=4, req=8'h10 held with no done -> gnt is high for exactly 4 cycles, timeout pulses for 1 cycle as gnt falls, then a regrant of 4 after the RELEASE cycle.
- Simultaneous events: en falls in the same cycle as done and the counter reaching MAX_HOLD-1 -> grant revoked, timeout stays 0, no new grant while en=0.

Source files
------------

// File: rtl/req_arbiter8.sv
// Eight-way request arbiter: highest-index-first search from a priority pointer,
// registered one-hot grant with hold limit. Define ROUND_ROBIN_EN to rotate the pointer.
module req_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state;
  logic [7:0] hold_cnt;
  logic [2:0] ptr;

  // rot[k] is the request k positions below ptr, so the lowest set bit of rot wins.
  logic [7:0] rot;
  logic [2:0] offset;
  logic       found;
  logic [2:0] win;

  for (genvar gi = 0; gi < 8; gi++) begin : g_rot
    assign rot[gi] = req[3'(ptr - 3'(gi))];
  end

  always_comb begin
    offset = 3'd0;
    for (int j = 7; j >= 0; j--) begin
      if (rot[j]) offset = 3'(j);
    end
    found = |rot;
    win   = ptr - offset;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= 8'd0;
      ptr       <= 3'd7;
      gnt       <= 8'h00;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (en && found) begin
            gnt       <= 8'b1 << win;
            gnt_idx   <= win;
            gnt_valid <= 1'b1;
            hold_cnt  <= 8'd0;
            state     <= BUSY;
`ifdef ROUND_ROBIN_EN
            ptr       <= win - 3'd1;
`endif
          end
        end
        BUSY: begin
          if (!en || done || !req[gnt_idx] || hold_cnt == HOLD_LAST) begin
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            state     <= RELEASE;
            // Only flag a timeout when the hold limit is the sole reason to let go.
            timeout   <= en && !done && req[gnt_idx];
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_req_arbiter8.sv
// Self-checking bench for req_arbiter8: an owner/age model checked every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_req_arbiter8;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  req_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the resource, how many cycles it has been visible, dead cycle flag.
  int   m_owner = -1;
  int   m_age = 0;
  bit   m_dead = 1'b0;
  int   m_ptr = 7;
  bit   m_to = 1'b0;

  function automatic int pick(input int p, input logic [7:0] r);
    int w;
    int c;
    w = -1;
    for (int j = 0; j < 8; j++) begin
      c = (p - j + 8) % 8;
      if (w < 0 && r[c]) w = c;
    end
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_age = 0; m_dead = 1'b0; m_ptr = 7; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_dead) begin
        m_dead = 1'b0;
      end else if (m_owner < 0) begin
        if (en && req != 8'h00) begin
          m_owner = pick(m_ptr, req);
          m_age = 1;
`ifdef ROUND_ROBIN_EN
          m_ptr = (m_owner + 7) % 8;
`endif
        end
      end else begin
        if (!en || done || !req[m_owner]) begin
          m_owner = -1; m_dead = 1'b1;
        end else if (m_age == MH) begin
          m_owner = -1; m_dead = 1'b1; m_to = 1'b1;
        end else begin
          m_age++;
        end
      end
    end
    #1;
    chk("model_gnt", gnt, (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00);
    chk("model_idx", {5'd0, gnt_idx}, (m_owner >= 0) ? 8'(m_owner) : 8'h00);
    chk("model_valid", {7'd0, gnt_valid}, {7'd0, (m_owner >= 0)});
    chk("model_timeout", {7'd0, timeout}, {7'd0, m_to});
  end

  // Drive one cycle of inputs at a falling edge; return at the next falling edge.
  task automatic cyc(input logic e, input logic [7:0] r, input logic d);
    en = e; req = r; done = d;
    @(negedge clk);
    $display("cyc en=%0b req=%h done=%0b -> gnt=%h idx=%0d valid=%0b to=%0b",
             e, r, d, gnt, gnt_idx, gnt_valid, timeout);
  endtask

  int exp_idx;

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_gnt", gnt, 8'h00);
    chk("reset_valid", {7'd0, gnt_valid}, 8'h00);

    // Single request, done pulse, dead cycle.
    cyc(1'b1, 8'h04, 1'b0);
    chk("single_gnt", gnt, 8'h04);
    chk("single_idx", {5'd0, gnt_idx}, 8'd2);
    cyc(1'b1, 8'h04, 1'b1);
    chk("single_done_gnt", gnt, 8'h00);
    cyc(1'b1, 8'h04, 1'b0);
    chk("single_release_gnt", gnt, 8'h00);
    cyc(1'b1, 8'h00, 1'b0);

    // Reset pulled mid-grant drops outputs without a clock edge.
    cyc(1'b1, 8'h20, 1'b0);
    chk("mid_gnt", gnt, 8'h20);
    #2 rst_n = 1'b0;
    #2;
    chk("rst_async_gnt", gnt, 8'h00);
    chk("rst_async_idx", {5'd0, gnt_idx}, 8'h00);
    chk("rst_async_valid", {7'd0, gnt_valid}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Requesters 7 and 0 both held; done pulsed on every grant.
    for (int n = 0; n < 4; n++) begin
      cyc(1'b1, 8'h81, 1'b0);
`ifdef ROUND_ROBIN_EN
      exp_idx = (n % 2 == 0) ? 7 : 0;
`else
      exp_idx = 7;
`endif
      chk("prio_idx", {5'd0, gnt_idx}, 8'(exp_idx));
      cyc(1'b1, 8'h81, 1'b1);
      cyc(1'b1, 8'h81, 1'b0);
    end
    cyc(1'b1, 8'h00, 1'b0);

    // Hold limit: visible for exactly MH cycles, then timeout with gnt falling.
    cyc(1'b1, 8'h10, 1'b0);
    chk("to_gnt0", gnt, 8'h10);
    for (int n = 0; n < MH - 1; n++) begin
      cyc(1'b1, 8'h10, 1'b0);
      chk("to_hold", gnt, 8'h10);
    end
    cyc(1'b1, 8'h10, 1'b0);
    chk("to_drop_gnt", gnt, 8'h00);
    chk("to_pulse", {7'd0, timeout}, 8'h01);
    cyc(1'b1, 8'h10, 1'b0);
    chk("to_dead_gnt", gnt, 8'h00);
    chk("to_pulse_end", {7'd0, timeout}, 8'h00);
    cyc(1'b1, 8'h10, 1'b0);
    chk("regrant_gnt", gnt, 8'h10);

    // Higher request arriving mid-grant is ignored, then en/done/limit coincide.
    for (int n = 0; n < MH - 1; n++) begin
      cyc(1'b1, 8'h90, 1'b0);
      chk("nonowner_ignored", gnt, 8'h10);
    end
    cyc(1'b0, 8'h90, 1'b1);
    chk("simul_gnt", gnt, 8'h00);
    chk("simul_timeout", {7'd0, timeout}, 8'h00);
    for (int n = 0; n < 3; n++) begin
      cyc(1'b0, 8'h90, 1'b0);
      chk("en_low_no_grant", {7'd0, gnt_valid}, 8'h00);
    end
    cyc(1'b1, 8'h90, 1'b0);
    chk("en_back_idx", {5'd0, gnt_idx}, 8'd7);

    // Owner drops its own request.
    cyc(1'b1, 8'h10, 1'b0);
    chk("req_drop_gnt", gnt, 8'h00);
    chk("req_drop_timeout", {7'd0, timeout}, 8'h00);
    cyc(1'b1, 8'h00, 1'b1);
    cyc(1'b1, 8'h00, 1'b0);
    chk("idle_done_ignored", {7'd0, gnt_valid}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
